dmem_ctrl: RTL and testbench

Data-memory controller between the pipeline's MEM stage, a word-wide DMA/debug port, and the single-port word-indexed data memory. It arbitrates the two requesters with anti-starvation priority. It converts CPU byte addresses to word indices and performs RISC-V byte/half stores as a read-modify-write sequence on the correct byte lane. It sign- or zero-extends sub-word loads and flags misaligned or out-of-range accesses.

---
 rtl/dmem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU/DMA arbitration, sub-word load extension
// and read-modify-write byte/half stores onto a word-wide memory.
module dmem_ctrl #(
  parameter int DEPTH        = 70,
  parameter int AW           = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [2:0]    cpu_funct3,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ready,
  output logic          dma_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RMW_RD = 2'd2;
  localparam logic [1:0] RMW_WR = 2'd3;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state, state_nx;
  logic [SW-1:0] starve_cnt;

  logic          sel_dma;
  logic          lat_we;
  logic          lat_err;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_off;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [31:0]   merge_q;

  logic          any_req;
  logic          grant_dma;
  logic [AW-1:0] cpu_idx;
  logic          cpu_mis;
  logic          cpu_ill;
  logic          cpu_oor;
  logic          cpu_bad;
  logic          cpu_sub;
  logic          dma_oor;

  logic          done;
  logic [31:0]   rdata;
  logic [31:0]   load_ext;
  logic [31:0]   merged;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign any_req   = cpu_req | dma_req;
  // DMA wins only when alone or once the CPU has used up its streak
  assign grant_dma = dma_req & (~cpu_req | (starve_cnt == LIMIT));

  assign cpu_idx = cpu_addr[AW+1:2];
  assign cpu_oor = ({1'b0, cpu_idx} >= DEPTH_W)
                 | (|cpu_addr[31:AW+2]);
  assign dma_oor = ({1'b0, dma_addr} >= DEPTH_W);

  always_comb begin
    cpu_mis = 1'b0;
    cpu_ill = 1'b0;
    unique case (cpu_funct3)
      3'b000: cpu_mis = 1'b0;
      3'b001: cpu_mis = cpu_addr[0];
      3'b010: cpu_mis = |cpu_addr[1:0];
      3'b100: cpu_ill = cpu_we;
      3'b101: begin
        cpu_ill = cpu_we;
        cpu_mis = cpu_addr[0];
      end
      default: cpu_ill = 1'b1;
    endcase
  end

  assign cpu_bad = cpu_mis | cpu_ill | cpu_oor;
  assign cpu_sub = cpu_we & ~cpu_bad
                 & (cpu_funct3[1:0] != 2'b10);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (!grant_dma && cpu_sub) state_nx = RMW_RD;
          else                       state_nx = ACCESS;
        end
      end
      ACCESS: state_nx = IDLE;
      RMW_RD: state_nx = RMW_WR;
      RMW_WR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      sel_dma    <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_f3     <= 3'b000;
      lat_off    <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      merge_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        sel_dma <= grant_dma;
        if (grant_dma) begin
          lat_we    <= dma_we;
          lat_err   <= dma_oor;
          lat_f3    <= 3'b010;
          lat_off   <= 2'b00;
          lat_idx   <= dma_addr;
          lat_wdata <= dma_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_err   <= cpu_bad;
          lat_f3    <= cpu_funct3;
          lat_off   <= cpu_addr[1:0];
          lat_idx   <= cpu_idx;
          lat_wdata <= cpu_wdata;
        end
      end
      if (state == RMW_RD) merge_q <= mem_rdata;
      if (!dma_req)
        starve_cnt <= '0;
      else if (state == IDLE && grant_dma)
        starve_cnt <= '0;
      else if (state == IDLE && cpu_req)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign lane_b = mem_rdata[{lat_off, 3'b000} +: 8];
  assign lane_h = lat_off[1] ? mem_rdata[31:16]
                             : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    unique case (lat_f3)
      3'b000: load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001: load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100: load_ext = {24'd0, lane_b};
      3'b101: load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (lat_f3[1:0] == 2'b00)
      merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
  end

  // reset masks everything so an aborted RMW never reaches memory
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    rdata     = '0;
    if (!rst) begin
      unique case (state)
        ACCESS: begin
          mem_addr = lat_idx;
          done     = 1'b1;
          if (!lat_err) begin
            if (lat_we) begin
              mem_we    = 1'b1;
              mem_wdata = lat_wdata;
            end else begin
              mem_re = 1'b1;
              rdata  = sel_dma ? mem_rdata : load_ext;
            end
          end
        end
        RMW_RD: begin
          mem_addr = lat_idx;
          mem_re   = 1'b1;
        end
        RMW_WR: begin
          mem_addr  = lat_idx;
          mem_we    = 1'b1;
          mem_wdata = merged;
          done      = 1'b1;
        end
        default: begin
          mem_addr = '0;
        end
      endcase
    end
  end

  assign cpu_ready = done & ~sel_dma;
  assign cpu_err   = done & ~sel_dma & lat_err;
  assign cpu_rdata = sel_dma ? 32'd0 : rdata;
  assign dma_ready = done & sel_dma;
  assign dma_err   = done & sel_dma & lat_err;
  assign dma_rdata = sel_dma ? rdata : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases plus randomized CPU/DMA traffic
// checked against a word-array reference of the data memory.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int DEPTH = 70;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [2:0]    cpu_funct3;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_err;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata, dma_rdata;
  logic          dma_ready, dma_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem  [0:127];
  logic [31:0] rmem [0:DEPTH-1];
  int checks = 0;
  int errors = 0;
  bit rec = 0;
  int seq = 0;
  logic outs_any;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  assign outs_any = |{cpu_rdata, cpu_ready, cpu_err, dma_rdata,
                      dma_ready, dma_err, mem_addr, mem_re,
                      mem_we, mem_wdata};

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .dma_ready(dma_ready), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: byte-addressed view of rmem, size from funct3
  task automatic cpu_expect(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr,
                            input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
    int size, sh;
    int unsigned idx;
    logic [31:0] mask, v;
    bit legal;
    legal = we ? (f3 <= 3'd2)
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    idx = addr / 4;
    err = !legal || (addr % size != 0) || (idx >= DEPTH);
    rd = 32'd0;
    if (!err) begin
      sh = 8 * int'(addr % 4);
      mask = (size == 4) ? 32'hFFFF_FFFF
                         : ((32'd1 << (8 * size)) - 32'd1);
      if (!we) begin
        v = (rmem[idx] >> sh) & mask;
        if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
        rd = v;
      end else begin
        rmem[idx] = (rmem[idx] & ~(mask << sh))
                  | ((wd & mask) << sh);
      end
    end
  endtask

  initial begin : cmp
    logic e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready_overlap", 32'(cpu_ready & dma_ready), 32'd0);
        if (cpu_ready) begin
          cpu_expect(cpu_we, cpu_funct3, cpu_addr, cpu_wdata, e, r);
          chk("cpu_err_model", 32'(cpu_err), 32'(e));
          if (!cpu_we || e) chk("cpu_rdata_model", cpu_rdata, r);
          if (rec) seq = seq * 2;
        end
        if (dma_ready) begin
          e = (int'(dma_addr) >= DEPTH);
          chk("dma_err_model", 32'(dma_err), 32'(e));
          if (e) chk("dma_rdata_model", dma_rdata, 32'd0);
          else if (dma_we) rmem[dma_addr] = dma_wdata;
          else chk("dma_rdata_model", dma_rdata, rmem[dma_addr]);
          if (rec) seq = seq * 2 + 1;
        end
      end
    end
  end

  task automatic cpu_op(input string nm, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat,
                        input logic xerr, input logic ckrd,
                        input logic [31:0] xrd);
    int n, wes;
    logic got, er;
    logic [31:0] rd;
    n = 0; wes = 0; got = 0; er = 0; rd = 0;
    @(negedge clk); #2;
    cpu_we = we; cpu_funct3 = f3; cpu_addr = addr;
    cpu_wdata = wd; cpu_req = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (mem_we) wes++;
      if (cpu_ready) begin
        got = 1; rd = cpu_rdata; er = cpu_err;
      end
    end
    #2 cpu_req = 1'b0;
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_err"}, 32'(er), 32'(xerr));
    if (ckrd) chk({nm, "_rdata"}, rd, xrd);
    chk({nm, "_we"}, 32'(wes), (we && !xerr) ? 32'd1 : 32'd0);
  endtask

  task automatic dma_op(input string nm, input logic we,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic xerr, input logic ckrd,
                        input logic [31:0] xrd);
    int n, wes;
    logic got, er;
    logic [31:0] rd;
    n = 0; wes = 0; got = 0; er = 0; rd = 0;
    @(negedge clk); #2;
    dma_we = we; dma_addr = a; dma_wdata = wd; dma_req = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (mem_we) wes++;
      if (dma_ready) begin
        got = 1; rd = dma_rdata; er = dma_err;
      end
    end
    #2 dma_req = 1'b0;
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'd1);
    chk({nm, "_err"}, 32'(er), 32'(xerr));
    if (ckrd) chk({nm, "_rdata"}, rd, xrd);
    chk({nm, "_we"}, 32'(wes), (we && !xerr) ? 32'd1 : 32'd0);
  endtask

  task automatic cpu_drive(input int nops, input int gap);
    int n, r, k;
    logic got;
    logic [31:0] a;
    @(negedge clk); #2;
    for (int i = 0; i < nops; i++) begin
      r = int'($urandom_range(0, 9));
      cpu_we = 1'($urandom_range(0, 1));
      if (r == 0) cpu_funct3 = 3'($urandom_range(0, 7));
      else if (cpu_we) cpu_funct3 = 3'($urandom_range(0, 2));
      else begin
        k = int'($urandom_range(0, 4));
        cpu_funct3 = (k > 2) ? 3'(k + 1) : 3'(k);
      end
      a = 32'($urandom_range(0, DEPTH + 1)) * 32'd4;
      if (r == 1) a = a + 32'($urandom_range(1, 3));
      else if (cpu_funct3[1:0] == 2'b00)
        a = a + 32'($urandom_range(0, 3));
      else if (cpu_funct3[1:0] == 2'b01)
        a = a + 32'd2 * 32'($urandom_range(0, 1));
      if (r == 2) a = a | (32'd1 << $urandom_range(9, 31));
      cpu_addr = a;
      cpu_wdata = $urandom;
      cpu_req = 1'b1;
      n = 0; got = 0;
      while (!got && n < 50) begin
        @(negedge clk); n++;
        if (cpu_ready) got = 1;
      end
      chk("cpu_rand_done", 32'(got), 32'd1);
      #2;
      r = int'($urandom_range(0, gap));
      if (r > 0) begin
        cpu_req = 1'b0;
        repeat (r) @(negedge clk);
        #2;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic dma_drive(input int nops, input int gap);
    int n, r;
    logic got;
    @(negedge clk); #2;
    for (int i = 0; i < nops; i++) begin
      dma_we = 1'($urandom_range(0, 1));
      dma_addr = AW'($urandom_range(0, DEPTH));
      dma_wdata = $urandom;
      dma_req = 1'b1;
      n = 0; got = 0;
      while (!got && n < 50) begin
        @(negedge clk); n++;
        if (dma_ready) got = 1;
      end
      chk("dma_rand_done", 32'(got), 32'd1);
      #2;
      r = int'($urandom_range(0, gap));
      if (r > 0) begin
        dma_req = 1'b0;
        repeat (r) @(negedge clk);
        #2;
      end
    end
    dma_req = 1'b0;
  endtask

  initial begin
    int bad;
    logic [31:0] old;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_funct3 = 0;
    cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(outs_any), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 32'(outs_any), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      dma_op("preload", 1'b1, AW'(i),
             (i == 5) ? 32'h0000_0014 :
             (i == 7) ? 32'hA521_4AAB : $urandom,
             1'b0, 1'b0, 32'd0);

    cpu_op("lw14", 0, 3'd2, 32'h14, 0, 1, 0, 1, 32'h0000_0014);
    cpu_op("lb1c", 0, 3'd0, 32'h1C, 0, 1, 0, 1, 32'hFFFF_FFAB);
    cpu_op("lbu1c", 0, 3'd4, 32'h1C, 0, 1, 0, 1, 32'h0000_00AB);
    cpu_op("lhu1e", 0, 3'd5, 32'h1E, 0, 1, 0, 1, 32'h0000_A521);
    cpu_op("lh1e", 0, 3'd1, 32'h1E, 0, 1, 0, 1, 32'hFFFF_A521);
    cpu_op("lh1c", 0, 3'd1, 32'h1C, 0, 1, 0, 1, 32'h0000_4AAB);
    cpu_op("sb1d", 1, 3'd0, 32'h1D, 32'hFFFF_FF55, 2, 0, 0, 0);
    cpu_op("lw1c_a", 0, 3'd2, 32'h1C, 0, 1, 0, 1, 32'hA521_55AB);
    cpu_op("sh1e", 1, 3'd1, 32'h1E, 32'hABCD_1234, 2, 0, 0, 0);
    cpu_op("lw1c_b", 0, 3'd2, 32'h1C, 0, 1, 0, 1, 32'h1234_55AB);
    cpu_op("lw02", 0, 3'd2, 32'h02, 0, 1, 1, 1, 32'd0);
    cpu_op("sh01", 1, 3'd1, 32'h01, 32'hAAAA, 1, 1, 1, 32'd0);
    cpu_op("lw118", 0, 3'd2, 32'h118, 0, 1, 1, 1, 32'd0);
    cpu_op("ld_f3_3", 0, 3'd3, 32'h18, 0, 1, 1, 1, 32'd0);
    cpu_op("st_f3_4", 1, 3'd4, 32'h18, 32'h77, 1, 1, 1, 32'd0);
    cpu_op("lw_high", 0, 3'd2, 32'h8000_0014, 0, 1, 1, 1, 32'd0);
    cpu_op("sw114", 1, 3'd2, 32'h114, 32'hCAFE_F00D, 1, 0, 0, 0);
    cpu_op("lw114_a", 0, 3'd2, 32'h114, 0, 1, 0, 1, 32'hCAFE_F00D);
    dma_op("dw69", 1, AW'(69), 32'hDEAD_BEEF, 0, 0, 32'd0);
    dma_op("dr69", 0, AW'(69), 32'd0, 0, 1, 32'hDEAD_BEEF);
    dma_op("dr70", 0, AW'(70), 32'd0, 1, 1, 32'd0);
    dma_op("dw70", 1, AW'(70), 32'h1111_2222, 1, 1, 32'd0);
    cpu_op("lw114_b", 0, 3'd2, 32'h114, 0, 1, 0, 1, 32'hDEAD_BEEF);

    // both ports held: expect C C C C D C C C C D
    seq = 0;
    rec = 1;
    fork
      cpu_drive(8, 0);
      dma_drive(2, 0);
    join
    rec = 0;
    chk("arb_sequence", 32'(seq), 32'b0000100001);

    fork
      cpu_drive(200, 3);
      dma_drive(100, 4);
    join

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== rmem[i]) bad++;
    chk("mem_sweep", 32'(bad), 32'd0);

    old = rmem[10];
    repeat (2) @(negedge clk);
    #2;
    cpu_we = 1; cpu_funct3 = 3'd0; cpu_addr = 32'h29;
    cpu_wdata = ~old; cpu_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rmw_wr_reached", 32'(mem_we), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst_masks_we", 32'(mem_we | cpu_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_outputs", 32'(outs_any), 32'd0);
    chk("rst_mem_unchanged", mem[10], old);
    cpu_op("lw28_after", 0, 3'd2, 32'h28, 0, 1, 0, 1, old);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
